// File: rtl/kv_priority_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : kv_priority_dispatch
//  Description : Single valid/ready input stream buffered in a small FIFO and
//                dispatched, one item per cycle, to the lowest-index output
//                lane that can accept it. Each lane is a registered
//                valid/data output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module kv_priority_dispatch #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_NUM   = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic [DATA_NUM-1:0]               o_valid,
    input  logic [DATA_NUM-1:0]               i_ready,
    output logic [DATA_WIDTH-1:0]             o_datas [DATA_NUM-1:0],
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count
);

    // Pointer width is forced to at least one bit so a single-entry FIFO works.
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_NUM-1:0]   w_free;
    logic [DATA_NUM-1:0]   w_grant;
    logic [DATA_NUM-1:0]   w_lane_valid;

    // o_ready depends on the registered count only, so a lane consuming in
    // the same cycle never opens the input combinationally.
    assign o_ready    = (r_count != c_CNT_FULL);
    assign o_count    = r_count;
    assign w_push     = i_valid & o_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];

    // A lane can take a new item if it is empty or is being consumed now.
    assign w_free  = ~w_lane_valid | i_ready;
    // Isolate the lowest set bit: the lowest-index free lane wins.
    assign w_grant = w_free & (~w_free + DATA_NUM'(1));
    assign w_pop   = w_nonempty & (|w_free);

    // Data storage, written at the tail on every accepted push
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write pointer, wraps modulo FIFO_DEPTH
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
        end
    end

    // Read pointer, advances on each dispatch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-lane output stage; each lane owns its own valid/data registers
    generate
        for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_lane
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_data;

            // Load on grant (also covers fire-and-reload), clear on fire
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_pop & w_grant[gi]) begin
                    r_valid <= 1'b1;
                    r_data  <= w_head;
                end else if (r_valid & i_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_lane_valid[gi] = r_valid;
            assign o_valid[gi]      = r_valid;
            assign o_datas[gi]      = r_data;
        end
    endgenerate

    // Occupancy must stay within 0..FIFO_DEPTH
    a_count_max: assert property (@(posedge i_clk) disable iff (i_rst)
        r_count <= c_CNT_FULL);
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_pop && (r_count == '0)));
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && !w_pop && (r_count == c_CNT_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_kv_priority_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kv_priority_dispatch
//  Description : Scoreboard bench for kv_priority_dispatch. Drivers push
//                accepted items into an expected queue; a negedge monitor
//                detects lane loads, checks order, lane choice, hold and
//                occupancy against a small occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kv_priority_dispatch;

    localparam int DW = 32;
    localparam int DN = 2;
    localparam int FD = 2;
    localparam int CW = $clog2(FD + 1);

    logic          i_clk   = 1'b0;
    logic          i_rst   = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data  = '0;
    logic [DN-1:0] o_valid;
    logic [DN-1:0] i_ready = '0;
    logic [DW-1:0] o_datas [DN-1:0];
    logic [CW-1:0] o_count;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    int loads [DN];

    kv_priority_dispatch #(
        .DATA_WIDTH (DW),
        .DATA_NUM   (DN),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_datas (o_datas),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Monitor: predictions made at one negedge are checked at the next
    // ------------------------------------------------------------------
    logic          have_prev = 1'b0;
    logic [DN-1:0] pv, pf, m_free;
    logic [DW-1:0] pd [DN];
    int            model_cnt = 0;
    int            pred_pop  = 0;
    int            pred_lane = -1;
    int            m_nl;
    logic          m_loaded;

    initial for (int i = 0; i < DN; i++) loads[i] = 0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            have_prev = 1'b0;
            model_cnt = 0;
        end else begin
            if (have_prev) begin
                chk("count", o_count, model_cnt);
                chk("ready", o_ready, model_cnt != FD);
                m_nl = 0;
                for (int i = 0; i < DN; i++) begin
                    m_loaded = o_valid[i] && (!pv[i] || pf[i]);
                    if (m_loaded) begin
                        m_nl++;
                        loads[i]++;
                        chk("lane_sel", i, pred_lane);
                        if (exp_q.size() == 0) begin
                            timeout("extra_item_no_expectation");
                        end else begin
                            chk("data_order", o_datas[i], exp_q.pop_front());
                        end
                    end
                    if (pv[i] && !pf[i]) begin
                        chk("hold_valid", o_valid[i], 1'b1);
                        chk("hold_data", o_datas[i], pd[i]);
                    end
                end
                chk("dispatch_cnt", m_nl, pred_pop);
            end
            pv     = o_valid;
            pf     = o_valid & i_ready;
            m_free = ~o_valid | i_ready;
            for (int i = 0; i < DN; i++) pd[i] = o_datas[i];
            pred_pop  = ((model_cnt != 0) && (|m_free)) ? 1 : 0;
            pred_lane = -1;
            for (int i = DN - 1; i >= 0; i--) if (m_free[i]) pred_lane = i;
            model_cnt = model_cnt + ((i_valid && model_cnt != FD) ? 1 : 0) - pred_pop;
            have_prev = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        i_valid = 1'b1;
        i_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                exp_q.push_back(d);
                tick();
                i_valid = 1'b0;
                return;
            end
            tick();
        end
        i_valid = 1'b0;
        timeout("push_accept");
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = '1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (exp_q.size() == 0 && o_valid == '0 && o_count == '0) return;
        end
        timeout("drain");
    endtask

    int  s0, s1;
    time t0, t1;

    initial begin
        // Reset state, observed before any clock edge
        #1;
        chk("rst_valid", o_valid, '0);
        chk("rst_count", o_count, '0);
        chk("rst_ready", o_ready, 1'b1);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // 1: asynchronous reset with two items buffered
        i_ready = '0;
        push_one(32'h11);
        push_one(32'h12);
        push_one(32'h13);
        push_one(32'h14);
        chk("t1_count_before", o_count, 2);
        chk("t1_valid_before", o_valid, 2'b11);
        #2;
        i_rst = 1'b1;
        #1;
        chk("t1_valid_async", o_valid, '0);
        chk("t1_count_async", o_count, '0);
        chk("t1_ready_async", o_ready, 1'b1);
        chk("t1_data0_async", o_datas[0], '0);
        chk("t1_data1_async", o_datas[1], '0);
        exp_q.delete();
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // 2: latency
        i_ready = 2'b11;
        i_valid = 1'b1;
        i_data  = 32'hA5;
        @(negedge i_clk);
        chk("t2_ready", o_ready, 1'b1);
        exp_q.push_back(32'hA5);
        tick();
        i_valid = 1'b0;
        chk("t2_count_t", o_count, 1);
        chk("t2_valid_t", o_valid, 2'b00);
        tick();
        chk("t2_valid_t1", o_valid, 2'b01);
        chk("t2_data_t1", o_datas[0], 32'hA5);
        chk("t2_count_t1", o_count, 0);
        drain();

        // 3: priority and reload of lane 1
        i_ready = 2'b00;
        push_one(32'h1);
        push_one(32'h2);
        push_one(32'h3);
        chk("t3_valid", o_valid, 2'b11);
        chk("t3_lane0", o_datas[0], 32'h1);
        chk("t3_lane1", o_datas[1], 32'h2);
        chk("t3_count", o_count, 1);
        i_ready = 2'b10;
        tick();
        i_ready = 2'b00;
        chk("t3_reload_lane1", o_datas[1], 32'h3);
        chk("t3_reload_lane0", o_datas[0], 32'h1);
        chk("t3_reload_valid", o_valid, 2'b11);
        chk("t3_reload_count", o_count, 0);
        drain();

        // 4: full
        i_ready = 2'b00;
        push_one(32'h40);
        push_one(32'h41);
        push_one(32'h42);
        push_one(32'h43);
        chk("t4_full_ready", o_ready, 1'b0);
        chk("t4_full_count", o_count, 2);
        i_valid = 1'b1;
        i_data  = 32'h99;
        tick();
        tick();
        tick();
        i_valid = 1'b0;
        chk("t4_ignored_count", o_count, 2);
        chk("t4_ignored_ready", o_ready, 1'b0);
        i_ready = 2'b01;
        tick();
        i_ready = 2'b00;
        chk("t4_after_fire_ready", o_ready, 1'b1);
        chk("t4_after_fire_count", o_count, 1);
        chk("t4_after_fire_lane0", o_datas[0], 32'h42);
        chk("t4_after_fire_valid", o_valid, 2'b11);
        drain();

        // 5: streaming through lane 0
        i_ready = 2'b01;
        s0 = loads[0];
        s1 = loads[1];
        t0 = $time;
        for (int d = 0; d < 100; d++) push_one(DW'(d));
        t1 = $time;
        chk("t5_rate_cycles", (t1 - t0) / 10, 100);
        drain();
        chk("t5_lane0_loads", loads[0] - s0, 100);
        chk("t5_lane1_loads", loads[1] - s1, 0);

        // 6: random traffic
        for (int c = 0; c < 10000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = $urandom;
            i_ready = DN'($urandom_range(0, 3));
            @(negedge i_clk);
            if (i_valid && o_ready) exp_q.push_back(i_data);
            tick();
        end
        drain();
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_final_count", o_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
